// File: rtl/modulo_temporizador_regressivo_pkg.sv
// Shared definitions for the MM:SS countdown timer: FSM encoding, BCD
// digit limits, field offsets of the 16-bit packing and the preset clamp.
package pkg_temporizador;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } estado_t;

    localparam logic [3:0] BCD_MAX_UNI     = 4'd9;
    localparam logic [3:0] BCD_MAX_DEZ_SEG = 4'd5;

    // Bit offsets of each digit inside {min_tens, min_units, sec_tens, sec_units}
    localparam int OFS_SEG_UNI = 0;
    localparam int OFS_SEG_DEZ = 4;
    localparam int OFS_MIN_UNI = 8;
    localparam int OFS_MIN_DEZ = 12;

    // Saturate one digit at its maximum legal value
    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max_v);
        logic [3:0] r;
        if (d > max_v) begin
            r = max_v;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Force an arbitrary preset into a legal MM:SS BCD value
    function automatic logic [15:0] clamp_preset(input logic [15:0] p);
        logic [15:0] r;
        r[OFS_MIN_DEZ +: 4] = clamp_digit(p[OFS_MIN_DEZ +: 4], BCD_MAX_UNI);
        r[OFS_MIN_UNI +: 4] = clamp_digit(p[OFS_MIN_UNI +: 4], BCD_MAX_UNI);
        r[OFS_SEG_DEZ +: 4] = clamp_digit(p[OFS_SEG_DEZ +: 4], BCD_MAX_DEZ_SEG);
        r[OFS_SEG_UNI +: 4] = clamp_digit(p[OFS_SEG_UNI +: 4], BCD_MAX_UNI);
        return r;
    endfunction

endpackage

// File: rtl/modulo_temporizador_regressivo_decrementa_bcd.sv
// One BCD digit of the countdown borrow chain. Purely combinational: the
// owning module holds the register. When enabled and asked to decrement,
// a zero digit wraps to MAX and propagates a borrow to the next digit.
module modulo_decrementa_bcd
    import pkg_temporizador::*;
#(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       en,
    input  logic       borrow_in,
    input  logic [3:0] digit_in,
    output logic [3:0] digit,
    output logic       borrow_out
);

    // Decrement with wrap-around and borrow generation
    always_comb begin
        digit      = digit_in;
        borrow_out = 1'b0;
        if (en && borrow_in) begin
            if (digit_in == 4'd0) begin
                digit      = MAX;
                borrow_out = 1'b1;
            end else begin
                digit      = digit_in - 4'd1;
                borrow_out = 1'b0;
            end
        end else begin
            digit      = digit_in;
            borrow_out = 1'b0;
        end
    end

endmodule

// File: rtl/modulo_temporizador_regressivo.sv
// MM:SS countdown timer. A divider tap is synchronised, edge-detected into
// a one-cycle tick and used to decrement a 4-digit BCD count under control
// of a start/pause/load FSM. All outputs are registered.
module modulo_temporizador_regressivo
    import pkg_temporizador::*;
#(
    parameter int TAP_SEL     = 19,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [19:0] q_div,
    input  logic        start,
    input  logic        pause,
    input  logic        load,
    input  logic [15:0] preset,
    output logic [15:0] tempo,
    output logic        done,
    output logic        running
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   edge_r;
    logic                   tick_s;
    logic                   unused_div_s;

    estado_t                state_r;
    estado_t                state_nxt_s;
    logic [15:0]            tempo_r;
    logic [15:0]            tempo_nxt_s;
    logic                   done_r;
    logic                   running_r;
    logic                   done_nxt_s;
    logic                   running_nxt_s;

    logic                   dec_en_s;
    logic [15:0]            dec_s;
    logic                   borrow_su_s;
    logic                   borrow_st_s;
    logic                   borrow_mu_s;
    logic                   borrow_mt_s;
    logic [15:0]            preset_cl_s;

    // Only one tap is used; the remaining divider bits are folded away
    assign unused_div_s = ^q_div;

    // Tap synchroniser and edge flop
    always_ff @(posedge clk) begin
        if (!clr) begin
            sync_r <= '0;
            edge_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], q_div[TAP_SEL]};
            edge_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign tick_s      = sync_r[SYNC_STAGES-1] & ~edge_r;
    assign preset_cl_s = clamp_preset(preset);

    // A tick only counts in RUN and is dropped when pause arrives with it
    assign dec_en_s = (state_r == RUN) && tick_s && !pause;

    modulo_decrementa_bcd #(.MAX(BCD_MAX_UNI)) u_seg_uni (
        .en         (dec_en_s),
        .borrow_in  (1'b1),
        .digit_in   (tempo_r[OFS_SEG_UNI +: 4]),
        .digit      (dec_s[OFS_SEG_UNI +: 4]),
        .borrow_out (borrow_su_s)
    );

    modulo_decrementa_bcd #(.MAX(BCD_MAX_DEZ_SEG)) u_seg_dez (
        .en         (dec_en_s),
        .borrow_in  (borrow_su_s),
        .digit_in   (tempo_r[OFS_SEG_DEZ +: 4]),
        .digit      (dec_s[OFS_SEG_DEZ +: 4]),
        .borrow_out (borrow_st_s)
    );

    modulo_decrementa_bcd #(.MAX(BCD_MAX_UNI)) u_min_uni (
        .en         (dec_en_s),
        .borrow_in  (borrow_st_s),
        .digit_in   (tempo_r[OFS_MIN_UNI +: 4]),
        .digit      (dec_s[OFS_MIN_UNI +: 4]),
        .borrow_out (borrow_mu_s)
    );

    // The final borrow never fires because 00:00 is never decremented
    modulo_decrementa_bcd #(.MAX(BCD_MAX_UNI)) u_min_dez (
        .en         (dec_en_s),
        .borrow_in  (borrow_mu_s),
        .digit_in   (tempo_r[OFS_MIN_DEZ +: 4]),
        .digit      (dec_s[OFS_MIN_DEZ +: 4]),
        .borrow_out (borrow_mt_s)
    );

    // State, count and decoded output registers
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_r   <= IDLE;
            tempo_r   <= 16'h0000;
            done_r    <= 1'b0;
            running_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            tempo_r   <= tempo_nxt_s;
            done_r    <= done_nxt_s;
            running_r <= running_nxt_s;
        end
    end

    // Next state and next count; priority is load > pause > start
    always_comb begin
        state_nxt_s = state_r;
        tempo_nxt_s = tempo_r;
        case (state_r)
            IDLE: begin
                if (load) begin
                    tempo_nxt_s = preset_cl_s;
                    state_nxt_s = IDLE;
                end else if (pause) begin
                    state_nxt_s = IDLE;
                end else if (start && (tempo_r != 16'h0000)) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (pause) begin
                    state_nxt_s = PAUSE;
                end else if (dec_en_s) begin
                    tempo_nxt_s = dec_s;
                    if (dec_s == 16'h0000) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end else begin
                    state_nxt_s = RUN;
                end
            end
            PAUSE: begin
                if (load) begin
                    tempo_nxt_s = preset_cl_s;
                    state_nxt_s = IDLE;
                end else if (pause) begin
                    state_nxt_s = PAUSE;
                end else if (start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = PAUSE;
                end
            end
            DONE: begin
                if (load) begin
                    tempo_nxt_s = preset_cl_s;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                tempo_nxt_s = 16'h0000;
            end
        endcase
    end

    // Decode status flags from the next state so they move with the state
    always_comb begin
        done_nxt_s    = 1'b0;
        running_nxt_s = 1'b0;
        case (state_nxt_s)
            RUN: begin
                running_nxt_s = 1'b1;
            end
            DONE: begin
                done_nxt_s = 1'b1;
            end
            default: begin
                done_nxt_s    = 1'b0;
                running_nxt_s = 1'b0;
            end
        endcase
    end

    assign tempo   = tempo_r;
    assign done    = done_r;
    assign running = running_r;

endmodule

// File: doc/modulo_temporizador_regressivo.md
Name: modulo_temporizador_regressivo

Overview:
- MM:SS countdown timer consuming the 20-bit ripple frequency-divider outputs, one stage downstream of the divider.
- One divider tap is synchronised into the system clock, edge-detected into a one-cycle tick enable, and used to decrement a 4-digit BCD count.
- A start/pause/load control FSM drives the count; count, done and running feed the display stage.

Parameters:
- TAP_SEL, 19: index of divider bit used as the time base. Tick period = 2^(TAP_SEL+1) clk cycles.
- SYNC_STAGES, 2: synchroniser depth for the selected tap (minimum 2).

Ports:
- clk  in  1: system clock. The divider chain runs from the same clk.
- clr  in  1: reset. One clock; reset is synchronous and active-low.
- q_div  in  20: divider outputs, q_div[0]=F/2 … q_div[19]=F/1048576.
- start  in  1: level, sampled each clk; starts or resumes counting.
- pause  in  1: level; freezes counting.
- load  in  1: level; copies preset into the count.
- preset  in  16: BCD {min_tens, min_units, sec_tens, sec_units}.
- tempo  out  16: current count, same packing as preset.
- done  out  1: high while in DONE.
- running  out  1: high while in RUN.

Behaviour:
- Reset: clr==0 at a rising clk edge gives, at that edge:
  - state=IDLE, tempo=16'h0000, done=0, running=0, all sync/edge flops 0.
  - Reset mid-RUN or mid-PAUSE aborts immediately; no tick is counted.
- Tick generation:
  - q_div[TAP_SEL] passes through SYNC_STAGES flops, then one edge flop; tick = last sync & ~edge flop.
  - The tap is first sampled high at edge N. With SYNC_STAGES=2, tick is high between N+1 and N+2, and the decrement registers at edge N+2.
  - Exactly one tick per tap rising edge.
- FSM states: IDLE, RUN, PAUSE, DONE. Input priority: load > pause > start.
- IDLE:
  - load: tempo<=clamped preset; stay IDLE.
  - start with tempo!=0: RUN.
  - start with tempo==0: stay IDLE.
- RUN:
  - load is ignored.
  - pause: PAUSE; a tick in the same cycle is dropped.
  - tick: decrement tempo. If the result is 00:00, go to DONE in the same edge.
- PAUSE:
  - load: tempo<=clamped preset, go to IDLE.
  - start: RUN.
  - ticks ignored.
- DONE:
  - tempo holds 0000, done=1.
  - load: tempo<=clamped preset, go to IDLE, done=0.
  - start alone: no effect.
- Decrement rules:
  - sec_units 0→9 with borrow.
  - sec_tens 0→5 with borrow.
  - min_units 0→9 with borrow.
  - min_tens 0→9; decrement from 00:00 never occurs.
  - Examples: 10:00→09:59, 00:10→00:09, 01:00→00:59.
- Preset clamp, applied on load:
  - Any digit >9 becomes 9.
  - sec_tens >5 becomes 5.
  - Example: preset 16'h7C7A loads as 16'h7959.
- running and done are registered, decoded from next state, and change in the same edge as state.
- Tick and state are unrelated to how long start/pause are held. Holding start in RUN has no effect.

Decomposition:
- Shared package (pkg_temporizador):
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3.
  - BCD_MAX_UNI=4'd9, BCD_MAX_DEZ_SEG=4'd5.
  - Field offsets of the 16-bit packing.
- Sub-module modulo_decrementa_bcd: one BCD digit with parameterised max, inputs en/borrow_in, outputs digit/borrow_out. Instantiated 4× in a borrow chain.
- Tick synchroniser/edge detector stays inline.

Test Plan (TAP_SEL=1, tick every 4 clk; divider model drives q_div from clk):
- Reset: run with preset 16'h0130 loaded, assert clr=0 for one edge → tempo=0000, done=0, running=0. Then start=1 → state stays IDLE, running=0.
- Load 16'h0100 then start → running=1. After the first tick tempo=0059. After 60 ticks tempo=0000, done=1, running=0 on the same edge.
- Borrow chain: load 16'h1000, start, one tick → tempo=0959. Load 16'h0010, one tick → 0009.
- Pause: load 0010, start, after 3 ticks tempo=0007. Pause for 10 tick periods → tempo stays 0007. Start → next tick 0006. Pause coincident with tick → no decrement.
- Clamp and priority: load 16'h7C7A → tempo=7959. In RUN, load+pause together → load ignored, PAUSE entered. In PAUSE, load → IDLE with new preset.
- Timing: the tap rises with first sample at edge N → tempo changes exactly at edge N+2, one decrement per tap rising edge over 20 consecutive ticks.
